dmem_port_arbiter: RTL
======================

# dmem_port_arbiter

Shares the single byte-wide data memory (2^AW bytes, big-endian words) between two word-access requesters: port 0 (CPU load/store) and port 1 (loader/debug). Each granted 32-bit access is sequenced as four one-byte memory beats, most significant byte at the lowest address. Arbitration is round-robin, with a req/gnt/done handshake per port. The block sits between the requesters and the byte array and owns every memory address and write-enable.

## Interface
- `AW`, 5, byte-address width; memory depth is 2^AW bytes.

- `clk` in 1: the single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `r0_req`, `r1_req` in 1: access request; held stable with `we`/`addr`/`wdata` until `gnt`.
- `r0_we`, `r1_we` in 1: 1 = word write, 0 = word read.
- `r0_addr`, `r1_addr` in AW: byte address of the word's MSB.
- `r0_wdata`, `r1_wdata` in 32: write word.
- `r0_gnt`, `r1_gnt` out 1: one-cycle acceptance pulse; request fields are captured on this edge.
- `r0_done`, `r1_done` out 1: one-cycle completion pulse.
- `rdata` out 32: read word; valid from `done` until the next read's `done`.
- `err` out 1: one-cycle pulse coincident with `done` for a rejected access (config-dependent).
- `busy` out 1: high when state ≠ IDLE.
- `mem_addr` out AW: byte address to the array.
- `mem_we` out 1: byte write strobe.
- `mem_wdata` out 8: byte to write.
- `mem_rdata` in 8: combinational read of `mem_addr`.

## Operation
- States: IDLE, XFER, DONE.
  - IDLE: if any req, drive the winner's `gnt` combinationally, capture its fields and owner, clear beat counter `k`, and go to XFER.
  - XFER: beat `k` = 0..3 (2-bit counter).
    - `mem_addr` = (base + k) mod 2^AW.
    - Write: `mem_we` = 1, `mem_wdata` = wdata[31-8k -: 8].
    - Read: capture `mem_rdata` into byte k of a shift buffer, MSB first.
    - After k = 3, go to DONE.
  - DONE: pulse the owner's `done`; on a read, load `rdata` from the buffer; go to IDLE.
- Arbitration:
  - Single requester wins.
  - Both requesting: grant the port not granted last.
  - Last-grant pointer resets to port 1, so port 0 wins the first tie.
- A req still high when IDLE is re-entered is a new request; a requester must drop req after `gnt` unless it wants another access.
- Writes leave `rdata` unchanged.
- Outside XFER: `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0.
- Reset values: state IDLE, all `gnt`/`done`/`err` = 0, `rdata` = 0, `busy` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0, pointer = port 1.
- Reset mid-XFER: abort immediately with no `done`. Bytes already written stay in memory (partial word); the requester must reissue.

## Timing
- `gnt` in cycle T (IDLE); beats in T+1..T+4; `done` in T+5; IDLE at T+6.
- Request-to-done latency 5 cycles; sustained throughput 1 word per 6 cycles.
- No skid: requests arriving during XFER/DONE wait; `gnt` never asserts while `busy` = 1.
- Only one `gnt` and one `done` high per cycle.

## Configuration
- `DMEM_ARB_ALIGN_CHECK_EN` defined:
  - A request with addr[1:0] ≠ 0 is still granted, then goes IDLE→DONE directly (T+1).
  - `done` and `err` both pulse; no memory beats; `rdata` unchanged.
- `DMEM_ARB_ALIGN_CHECK_EN` undefined:
  - Any address is accepted; `err` is tied 0.
  - Byte addresses wrap modulo 2^AW (addr 30 → bytes 30, 31, 0, 1).

## Test plan
- Reset, then idle 3 cycles → `busy` = 0, `rdata` = 0, `mem_we` = 0, no gnt/done.
- r0 write 0xDEADBEEF @0x08, then r1 read @0x08 → bytes [8..11] = DE AD BE EF; `r1_done` at gnt+5 with `rdata` = 0xDEADBEEF.
- Both ports request continuously from the same cycle → grants r0, r1, r0, r1 spaced 6 cycles apart.
- r0 write 0x11223344 @0x1E (check undefined) → bytes 30 = 11, 31 = 22, 0 = 33, 1 = 44; with check defined → `err` and `done` at gnt+1, memory untouched.
- `reset` asserted during beat 2 of a write of 0xAABBCCDD @0x04 → bytes 4 and 5 = AA BB, bytes 6 and 7 unchanged, no `done`; state IDLE next cycle.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Shares one byte-wide data memory (2^AW bytes, big-endian words) between
//   two word-access requesters using round-robin arbitration. Each granted
//   32-bit access becomes four one-byte beats, MSB at the lowest address.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   rN_req/we/addr/wdata  : request from port N (held until rN_gnt)
//   rN_gnt                : one-cycle acceptance pulse (combinational in IDLE)
//   rN_done               : one-cycle completion pulse for port N
//   rdata                 : last read word, valid from its done pulse onward
//   err                   : pulses with done for a rejected (misaligned) access
//   busy                  : high whenever the sequencer is not IDLE
//   mem_addr/we/wdata     : byte-array address, write strobe, write byte
//   mem_rdata             : combinational read of mem_addr
//
// Configuration
//   DMEM_ARB_ALIGN_CHECK_EN : when defined, accesses with addr[1:0] != 0 are
//   granted but complete immediately with err and no memory beats. When
//   undefined, any address is accepted, bytes wrap modulo 2^AW, err is 0.
module dmem_port_arbiter #(
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [31:0]   r0_wdata,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [31:0]   r1_wdata,
  output logic          r0_gnt,
  output logic          r1_gnt,
  output logic          r0_done,
  output logic          r1_done,
  output logic [31:0]   rdata,
  output logic          err,
  output logic          busy,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t        state_q, state_d;
  logic [1:0]    k_q, k_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic          we_q, we_d;
  logic [AW-1:0] base_q, base_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [23:0]   buf_q, buf_d;
  logic [31:0]   rdata_q, rdata_d;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
  logic          err_q, err_d;
`endif

  logic          pick1;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [31:0]   sel_wdata;
  logic          in_done;

  // Next-state logic. last_q = 1 means port 1 was granted last, so on a tie
  // port 0 wins; a lone requester always wins.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    owner_d   = owner_q;
    last_d    = last_q;
    we_d      = we_q;
    base_d    = base_q;
    wdata_d   = wdata_q;
    buf_d     = buf_q;
    rdata_d   = rdata_q;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    err_d     = err_q;
`endif
    pick1     = r1_req && (!r0_req || !last_q);
    sel_we    = pick1 ? r1_we    : r0_we;
    sel_addr  = pick1 ? r1_addr  : r0_addr;
    sel_wdata = pick1 ? r1_wdata : r0_wdata;
    r0_gnt    = 1'b0;
    r1_gnt    = 1'b0;

    case (state_q)
      IDLE: begin
        if (r0_req || r1_req) begin
          r0_gnt  = !pick1 && !reset;
          r1_gnt  = pick1 && !reset;
          owner_d = pick1;
          last_d  = pick1;
          we_d    = sel_we;
          base_d  = sel_addr;
          wdata_d = sel_wdata;
          k_d     = 2'd0;
          state_d = XFER;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
          err_d   = 1'b0;
          if (sel_addr[1:0] != 2'b00) begin
            err_d   = 1'b1;
            state_d = DONE;
          end
`endif
        end
      end
      XFER: begin
        k_d = k_q + 2'd1;
        if (!we_q) begin
          buf_d = {buf_q[15:0], mem_rdata};
        end
        // The last byte is still combinational on mem_rdata, so rdata is
        // assembled here and is already valid during the DONE cycle.
        if (k_q == 2'd3) begin
          state_d = DONE;
          if (!we_q) begin
            rdata_d = {buf_q, mem_rdata};
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= 2'd0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      base_q  <= '0;
      wdata_q <= 32'd0;
      buf_q   <= 24'd0;
      rdata_q <= 32'd0;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      we_q    <= we_d;
      base_q  <= base_d;
      wdata_q <= wdata_d;
      buf_q   <= buf_d;
      rdata_q <= rdata_d;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  // Outputs are gated by reset so an abort takes effect in the same cycle:
  // the beat in flight when reset rises is never written.
  always_comb begin
    in_done   = (state_q == DONE) && !reset;
    r0_done   = in_done && !owner_q;
    r1_done   = in_done && owner_q;
    busy      = (state_q != IDLE);
    rdata     = rdata_q;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 8'd0;
    if (state_q == XFER && !reset) begin
      mem_addr = base_q + AW'(k_q);
      mem_we   = we_q;
      if (we_q) begin
        case (k_q)
          2'd0:    mem_wdata = wdata_q[31:24];
          2'd1:    mem_wdata = wdata_q[23:16];
          2'd2:    mem_wdata = wdata_q[15:8];
          default: mem_wdata = wdata_q[7:0];
        endcase
      end
    end
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    err = in_done && err_q;
`else
    err = 1'b0;
`endif
  end

endmodule
